pc_ras_unit: RTL and testbench

- Parametrised next-generation program counter for the instruction-fetch path.
- Drives the instruction-memory address and supports these control operations:
  - sequential increment;
  - stall;
  - absolute jump;
  - call with return-address push;
  - return via an internal return-address stack (RAS).
- Sits between the control decoder and instruction ROM.
- Replaces the fixed 10-bit, async-load counter with a fully synchronous, width/depth-configurable unit.

---
 rtl/pc_pkg.sv | 35 +++
 rtl/pc_ras_unit_if.sv | 26 ++
 rtl/pc_ras_stack.sv | 53 +++++
 rtl/pc_ras_unit.sv | 73 +++++++
 tb/tb_pc_ras_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-path program counter: op codes, op decode
// and stack-count width.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_SEQ,
    OP_JMP,
    OP_CALL,
    OP_RET,
    OP_ILLEGAL
  } op_e;

  localparam int RAS_DEPTH_DEF = 4;
  localparam int RAS_CNT_W     = $clog2(RAS_DEPTH_DEF + 1);

  // Width needed to hold 0..depth valid stack entries.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Stall dominates everything; any two flow-changing ops together are illegal.
  function automatic op_e decode_op(input logic stall, input logic pc_load,
                                    input logic call, input logic ret);
    op_e op;
    if (stall)                                           op = OP_HOLD;
    else if ((call && ret) || (call && pc_load) || (ret && pc_load)) op = OP_ILLEGAL;
    else if (ret)                                        op = OP_RET;
    else if (call)                                       op = OP_CALL;
    else if (pc_load)                                    op = OP_JMP;
    else                                                 op = OP_SEQ;
    return op;
  endfunction

endpackage

// File: rtl/pc_ras_unit_if.sv
// Control/status bundle between the decoder (master) and the PC unit (slave).
interface pc_ras_unit_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 3
);
  logic              stall;
  logic              pc_load;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] jump_ins;
  logic [ADDR_W-1:0] addr_ins;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_empty;
  logic              ras_full;
  logic              err;

  modport master (
    output stall, pc_load, call, ret, jump_ins,
    input  addr_ins, ras_count, ras_empty, ras_full, err
  );

  modport slave (
    input  stall, pc_load, call, ret, jump_ins,
    output addr_ins, ras_count, ras_empty, ras_full, err
  );
endinterface

// File: rtl/pc_ras_stack.sv
// Return-address stack: circular buffer with a top pointer; a push while full
// overwrites the oldest entry so the most recent RAS_DEPTH returns survive.
module ras_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int RAS_DEPTH = 4,
  localparam int CW = cnt_width(RAS_DEPTH),
  localparam int PW = $clog2(RAS_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_nxt;
  logic [PW-1:0]     ptr_prv;

  // Explicit wrap so non-power-of-two depths work.
  assign ptr_nxt = (ptr == PW'(RAS_DEPTH - 1)) ? '0 : ptr + PW'(1);
  assign ptr_prv = (ptr == '0) ? PW'(RAS_DEPTH - 1) : ptr - PW'(1);

  assign top   = mem[ptr];
  assign full  = (count == CW'(RAS_DEPTH));
  assign empty = (count == '0);

  always_ff @(negedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr_nxt;
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr_prv;
      count <= count - CW'(1);
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(negedge clk) begin
    if (!rst && push) mem[ptr_nxt] <= push_data;
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Fetch-path program counter with sequential/jump/call/return control and a
// return-address stack; all state moves on the falling edge of clk.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int              ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4,
  parameter int              STEP      = 1
) (
  input  logic          clk,
  input  logic          rst,
  pc_ras_unit_if.slave  bus
);

  localparam int CW = cnt_width(RAS_DEPTH);

  op_e               op;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_step;
  logic [ADDR_W-1:0] ras_top;
  logic [CW-1:0]     ras_cnt;
  logic              ras_full;
  logic              ras_empty;
  logic              push;
  logic              pop;
  logic              err_q;

  assign op      = decode_op(bus.stall, bus.pc_load, bus.call, bus.ret);
  assign pc_step = pc + ADDR_W'(STEP);
  assign push    = (op == OP_CALL);
  assign pop     = (op == OP_RET) && !ras_empty;

  ras_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_data(pc_step),
    .top      (ras_top),
    .count    (ras_cnt),
    .full     (ras_full),
    .empty    (ras_empty)
  );

  always_ff @(negedge clk) begin
    if (rst) begin
      pc    <= RESET_VEC;
      err_q <= 1'b0;
    end else begin
      case (op)
        OP_SEQ:          pc <= pc_step;
        OP_JMP, OP_CALL: pc <= bus.jump_ins;
        OP_RET:          if (!ras_empty) pc <= ras_top;
        default:         pc <= pc;
      endcase
      // Overflowing call still jumps; only the oldest return is lost.
      err_q <= (op == OP_ILLEGAL) ||
               ((op == OP_RET)  && ras_empty) ||
               ((op == OP_CALL) && ras_full);
    end
  end

  assign bus.addr_ins  = pc;
  assign bus.ras_count = ras_cnt;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Self-checking bench for pc_ras_unit: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_pc_ras_unit;
  localparam int AW = 10;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_ras_unit_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  pc_ras_unit #(
    .ADDR_W(AW), .RESET_VEC('0), .RAS_DEPTH(D), .STEP(1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: PC value, return stack as a queue (back = top), err flag.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_q[$];
  logic          m_err;

  task automatic model_step(input logic r, s, pl, c, rt, input logic [AW-1:0] j);
    int nops;
    nops = int'(pl) + int'(c) + int'(rt);
    if (r) begin
      m_pc = '0; m_q.delete(); m_err = 1'b0;
    end else if (s) begin
      m_err = 1'b0;
    end else if (nops > 1) begin
      m_err = 1'b1;
    end else if (rt) begin
      if (m_q.size() == 0) m_err = 1'b1;
      else begin m_pc = m_q.pop_back(); m_err = 1'b0; end
    end else if (c) begin
      m_q.push_back(m_pc + AW'(1));
      m_err = 1'b0;
      if (m_q.size() > D) begin void'(m_q.pop_front()); m_err = 1'b1; end
      m_pc = j;
    end else if (pl) begin
      m_pc = j; m_err = 1'b0;
    end else begin
      m_pc = m_pc + AW'(1); m_err = 1'b0;
    end
  endtask

  // Apply one set of controls across one falling edge, then settle.
  task automatic drive(input logic r, s, pl, c, rt, input logic [AW-1:0] j);
    rst = r; bus.stall = s; bus.pc_load = pl; bus.call = c; bus.ret = rt; bus.jump_ins = j;
    model_step(r, s, pl, c, rt, j);
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, 0, '0);
    checks++; if (bus.addr_ins !== 10'h000) begin errors++; $display("FAIL reset_addr got %h exp 000", bus.addr_ins); end
    checks++; if (bus.ras_count !== 3'd0 || bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL reset_state got cnt=%0d empty=%b full=%b err=%b exp 0 1 0 0",
                         bus.ras_count, bus.ras_empty, bus.ras_full, bus.err); end
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 0, 0, 0, '0);
      checks++; if (bus.addr_ins !== AW'(i)) begin errors++; $display("FAIL idle_inc got %h exp %h", bus.addr_ins, AW'(i)); end
    end
    drive(1, 0, 1, 0, 0, 10'h200);
    checks++; if (bus.addr_ins !== 10'h000 || bus.ras_count !== 3'd0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL reset_over_load got addr=%h cnt=%0d err=%b exp 000 0 0", bus.addr_ins, bus.ras_count, bus.err); end
  endtask

  task automatic test_wrap_stall();
    logic [AW-1:0] exp_a [3];
    exp_a[0] = 10'h3FF; exp_a[1] = 10'h000; exp_a[2] = 10'h001;
    drive(0, 0, 1, 0, 0, 10'h3FE);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, '0);
      checks++; if (bus.addr_ins !== exp_a[i] || bus.err !== 1'b0) begin
        errors++; $display("FAIL wrap got addr=%h err=%b exp %h 0", bus.addr_ins, bus.err, exp_a[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 0, 10'h155);
      checks++; if (bus.addr_ins !== 10'h001 || bus.ras_count !== 3'd0 || bus.err !== 1'b0) begin
        errors++; $display("FAIL stall got addr=%h cnt=%0d err=%b exp 001 0 0", bus.addr_ins, bus.ras_count, bus.err); end
    end
  endtask

  task automatic test_call_ret();
    drive(0, 0, 1, 0, 0, 10'h010);
    drive(0, 0, 0, 1, 0, 10'h100);
    checks++; if (bus.addr_ins !== 10'h100 || bus.ras_count !== 3'd1 || bus.err !== 1'b0) begin
      errors++; $display("FAIL call got addr=%h cnt=%0d err=%b exp 100 1 0", bus.addr_ins, bus.ras_count, bus.err); end
    drive(0, 0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, 0, '0);
    checks++; if (bus.addr_ins !== 10'h102) begin errors++; $display("FAIL call_body got %h exp 102", bus.addr_ins); end
    drive(0, 0, 0, 0, 1, '0);
    checks++; if (bus.addr_ins !== 10'h011 || bus.ras_count !== 3'd0 || bus.ras_empty !== 1'b1) begin
      errors++; $display("FAIL ret got addr=%h cnt=%0d empty=%b exp 011 0 1", bus.addr_ins, bus.ras_count, bus.ras_empty); end
  endtask

  task automatic test_nested();
    logic [AW-1:0] exp_r [4];
    exp_r[0] = 10'h131; exp_r[1] = 10'h121; exp_r[2] = 10'h111; exp_r[3] = 10'h101;
    drive(0, 0, 1, 0, 0, 10'h010);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 0, 10'h100 + AW'(16 * i));
      checks++; if (bus.err !== (i == 4) || bus.ras_count !== CW'((i < 4) ? i + 1 : 4)) begin
        errors++; $display("FAIL nested_call%0d got err=%b cnt=%0d", i, bus.err, bus.ras_count); end
    end
    checks++; if (bus.ras_full !== 1'b1 || bus.addr_ins !== 10'h140) begin
      errors++; $display("FAIL nested_full got full=%b addr=%h exp 1 140", bus.ras_full, bus.addr_ins); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, '0);
      checks++; if (bus.addr_ins !== exp_r[i] || bus.err !== 1'b0) begin
        errors++; $display("FAIL nested_ret%0d got addr=%h err=%b exp %h 0", i, bus.addr_ins, bus.err, exp_r[i]); end
    end
    drive(0, 0, 0, 0, 1, '0);
    checks++; if (bus.addr_ins !== 10'h101 || bus.err !== 1'b1 || bus.ras_empty !== 1'b1) begin
      errors++; $display("FAIL underflow got addr=%h err=%b empty=%b exp 101 1 1", bus.addr_ins, bus.err, bus.ras_empty); end
  endtask

  task automatic test_illegal();
    drive(0, 0, 1, 0, 0, 10'h050);
    drive(0, 0, 0, 1, 1, 10'h3C0);
    checks++; if (bus.addr_ins !== 10'h050 || bus.ras_count !== 3'd0 || bus.err !== 1'b1) begin
      errors++; $display("FAIL call_ret got addr=%h cnt=%0d err=%b exp 050 0 1", bus.addr_ins, bus.ras_count, bus.err); end
    drive(0, 0, 0, 0, 0, '0);
    checks++; if (bus.addr_ins !== 10'h051 || bus.err !== 1'b0) begin
      errors++; $display("FAIL err_clear got addr=%h err=%b exp 051 0", bus.addr_ins, bus.err); end
    drive(0, 0, 1, 1, 0, 10'h3C0);
    checks++; if (bus.addr_ins !== 10'h051 || bus.ras_count !== 3'd0 || bus.err !== 1'b1) begin
      errors++; $display("FAIL call_load got addr=%h cnt=%0d err=%b exp 051 0 1", bus.addr_ins, bus.ras_count, bus.err); end
    drive(0, 0, 1, 0, 1, 10'h3C0);
    checks++; if (bus.addr_ins !== 10'h051 || bus.err !== 1'b1) begin
      errors++; $display("FAIL ret_load got addr=%h err=%b exp 051 1", bus.addr_ins, bus.err); end
  endtask

  task automatic test_jump();
    drive(0, 0, 1, 0, 0, 10'h020);
    drive(0, 0, 0, 1, 0, 10'h080);
    drive(0, 0, 0, 1, 0, 10'h090);
    drive(0, 0, 1, 0, 0, 10'h2AA);
    checks++; if (bus.addr_ins !== 10'h2AA || bus.ras_count !== 3'd2 || bus.err !== 1'b0) begin
      errors++; $display("FAIL load_keep_stack got addr=%h cnt=%0d err=%b exp 2AA 2 0", bus.addr_ins, bus.ras_count, bus.err); end
    drive(0, 0, 0, 0, 1, '0);
    checks++; if (bus.addr_ins !== 10'h081 || bus.ras_count !== 3'd1) begin
      errors++; $display("FAIL ret_after_load got addr=%h cnt=%0d exp 081 1", bus.addr_ins, bus.ras_count); end
    drive(1, 0, 0, 1, 0, 10'h300);
    checks++; if (bus.addr_ins !== 10'h000 || bus.ras_count !== 3'd0) begin
      errors++; $display("FAIL mid_reset got addr=%h cnt=%0d exp 000 0", bus.addr_ins, bus.ras_count); end
  endtask

  task automatic test_random();
    logic r, s, pl, c, rt;
    drive(1, 0, 0, 0, 0, '0);
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(63) == 0);
      s  = ($urandom_range(7) == 0);
      pl = ($urandom_range(4) == 0);
      c  = ($urandom_range(3) == 0);
      rt = ($urandom_range(3) == 0);
      drive(r, s, pl, c, rt, AW'($urandom));
      checks++;
      if (bus.addr_ins !== m_pc || bus.ras_count !== CW'(m_q.size()) || bus.err !== m_err ||
          bus.ras_empty !== (m_q.size() == 0) || bus.ras_full !== (m_q.size() == D)) begin
        errors++;
        $display("FAIL random%0d got addr=%h cnt=%0d err=%b empty=%b full=%b exp addr=%h cnt=%0d err=%b",
                 n, bus.addr_ins, bus.ras_count, bus.err, bus.ras_empty, bus.ras_full,
                 m_pc, m_q.size(), m_err);
      end
    end
  endtask

  initial begin
    rst = 1'b1; bus.stall = 1'b0; bus.pc_load = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.jump_ins = '0;
    m_pc = '0; m_err = 1'b0;
    test_reset();
    test_wrap_stall();
    test_call_ret();
    test_nested();
    test_illegal();
    test_jump();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
